// File: rtl/demod_pkg.sv
// demod_pkg: shared defaults, I/Q pair layout and fixed-point helpers for the
// streaming FM demodulator.
package demod_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int FRAC_BITS_DEF  = 10;
  localparam int GAIN_DEF       = 758;

  // Holds (2W+1)-bit differences times a 32-bit gain for W up to 47.
  localparam int ACC_W = 128;

  typedef logic signed [ACC_W-1:0] acc_t;

  // Pair layout at the default width; real part sits in the upper half.
  typedef struct packed {
    logic signed [DATA_WIDTH_DEF-1:0] re;
    logic signed [DATA_WIDTH_DEF-1:0] im;
  } iq_pair_t;

  function automatic acc_t dequantize(input acc_t x, input int sh);
    return x >>> sh;
  endfunction

  function automatic acc_t sat_w(input acc_t x, input int w);
    acc_t hi;
    acc_t lo;
    acc_t res;
    hi = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
    lo = ~hi;
    res = x;
    if (x > hi) res = hi;
    else if (x < lo) res = lo;
    return res;
  endfunction

endpackage

// File: rtl/iq_pair_fifo.sv
// iq_pair_fifo: single-clock fifo with registered read data. Full/empty come
// from the pointer difference, using one extra wrap bit on each pointer.
module iq_pair_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [AW:0]      level;
  logic             do_wr;
  logic             do_rd;

  assign level = wptr - rptr;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[AW-1:0]] <= din;
  end

  // Pointer update and registered read port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      dout <= '0;
    end else begin
      if (do_wr) wptr <= wptr + (AW+1)'(1);
      if (do_rd) begin
        rptr <= rptr + (AW+1)'(1);
        dout <= mem[rptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/iq_demod_stream.sv
// iq_demod_stream: buffered I/Q input feeding a 4-stage FM polar discriminator
// (Q_n*I_{n-1} - I_n*Q_{n-1}, scaled by GAIN) with backpressure from the
// output fifo. Define DEMOD_SAT_EN to clamp the result to W bits instead of
// wrapping it.
module iq_demod_stream
  import demod_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FRAC_BITS  = FRAC_BITS_DEF,
  parameter int GAIN       = GAIN_DEF,
  parameter int IN_DEPTH   = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] real_in,
  input  logic [DATA_WIDTH-1:0] imag_in,
  input  logic                  in_wr_en,
  output logic                  in_full,
  output logic [DATA_WIDTH-1:0] demod_out,
  output logic                  out_wr_en,
  input  logic                  out_full,
  output logic                  overflow
);

  localparam int W  = DATA_WIDTH;
  localparam int PW = 2 * W;
  localparam int DW = 2 * W + 1;

  typedef struct packed {
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
  } pair_t;

  logic                 adv;
  logic                 rd;
  logic                 buf_empty;
  logic [PW-1:0]        buf_dout;
  pair_t                cur;
  pair_t                prev;
  logic                 s1_valid;
  logic                 s2_valid;
  logic                 s3_valid;
  logic                 s4_valid;
  logic signed [PW-1:0] s2_a;
  logic signed [PW-1:0] s2_b;
  logic signed [DW-1:0] s3_d;
  logic [W-1:0]         s4_out;
  logic [W-1:0]         s_red;

  function automatic acc_t scale(input acc_t d);
    return dequantize(dequantize(d, FRAC_BITS) * acc_t'(GAIN), FRAC_BITS);
  endfunction

  assign adv = !out_full;
  assign rd  = adv && !buf_empty;

  // The fifo's registered read port doubles as stage 1 (current sample).
  iq_pair_fifo #(
    .WIDTH (PW),
    .DEPTH (IN_DEPTH)
  ) u_in_buf (
    .clk   (clk),
    .reset (reset),
    .wr_en (in_wr_en),
    .din   ({real_in, imag_in}),
    .rd_en (rd),
    .dout  (buf_dout),
    .full  (in_full),
    .empty (buf_empty)
  );

  assign cur = pair_t'(buf_dout);

  // Rescale the stage-3 difference by GAIN and reduce it to the output width.
  always_comb begin
`ifdef DEMOD_SAT_EN
    s_red = W'(sat_w(scale(acc_t'(s3_d)), W));
`else
    s_red = W'(scale(acc_t'(s3_d)));
`endif
  end

  // All stages advance together; prev only follows real samples, not bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev     <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s4_valid <= 1'b0;
      s2_a     <= '0;
      s2_b     <= '0;
      s3_d     <= '0;
      s4_out   <= '0;
    end else if (adv) begin
      s1_valid <= rd;
      if (s1_valid) prev <= cur;
      s2_valid <= s1_valid;
      s2_a     <= PW'(cur.im) * PW'(prev.re);
      s2_b     <= PW'(cur.re) * PW'(prev.im);
      s3_valid <= s2_valid;
      s3_d     <= DW'(s2_a) - DW'(s2_b);
      s4_valid <= s3_valid;
      if (s3_valid) s4_out <= s_red;
    end
  end

  // Sticky record of any write attempted while the buffer was full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow <= 1'b0;
    else if (in_wr_en && in_full) overflow <= 1'b1;
  end

  assign demod_out = s4_out;
  assign out_wr_en = s4_valid && !out_full;

endmodule
